btb_update_scheduler: RTL and testbench



---
 rtl/btb_update_scheduler.sv | 159 +++++++++++++++
 tb/tb_btb_update_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_scheduler.sv
// Schedules resolved-branch updates from two execute ports onto the single BTB update port,
// and runs a full-array invalidate walk on a predictor flush request.
module btb_update_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SETS  = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_pc,
    input  logic [31:0]      req0_bta,
    input  logic [1:0]       req0_type,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_pc,
    input  logic [31:0]      req1_bta,
    input  logic [1:0]       req1_type,
    input  logic             inv_req,
    output logic             update_en,
    output logic [31:0]      update_pc,
    output logic [31:0]      update_BTA,
    output logic [1:0]       update_type,
    output logic             inv_en,
    output logic [IDX_W-1:0] inv_idx,
    output logic             busy,
    output logic [15:0]      upd_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SETS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WALK = 2'd2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] bta;
        logic [1:0]  kind;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             acc0;
    logic             acc1;
    logic             pop;
    logic             walk_last;

    // Ready is based on the registered occupancy only; port 1 sees port 0's slot first.
    assign req0_ready = (state != S_WALK) && (count <= CNT_LAST);
    assign acc0       = req0_valid && req0_ready;
    assign req1_ready = (state != S_WALK) && ((count + CNT_W'(acc0)) <= CNT_LAST);
    assign acc1       = req1_valid && req1_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        pop       = 1'b0;
        walk_last = (inv_idx == IDX_LAST);
        if (inv_req) begin
            state_nxt = S_WALK;
            count_nxt = '0;
        end else begin
            case (state)
                S_WALK: begin
                    if (walk_last) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    pop       = (count != '0);
                    count_nxt = count + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(pop);
                    state_nxt = (count_nxt == '0) ? S_IDLE : S_RUN;
                end
            endcase
        end
    end

    // Pointers and occupancy; a flush request drops everything queued, including same-cycle accepts.
    always_ff @(posedge clk) begin
        if (!resetn || inv_req) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop);
            tail  <= tail + PTR_W'(acc0) + PTR_W'(acc1);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (acc0) begin
            mem[tail] <= '{pc: req0_pc, bta: req0_bta, kind: req0_type};
        end
        if (acc1) begin
            mem[tail + PTR_W'(acc0)] <= '{pc: req1_pc, bta: req1_bta, kind: req1_type};
        end
    end

    // upd_count advances on the same edge that raises update_en, so they are visible together.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            update_en   <= 1'b0;
            update_pc   <= '0;
            update_BTA  <= '0;
            update_type <= '0;
            upd_count   <= '0;
        end else begin
            update_en <= pop;
            if (pop) begin
                update_pc   <= mem[head].pc;
                update_BTA  <= mem[head].bta;
                update_type <= mem[head].kind;
                if (upd_count != 16'hFFFF) begin
                    upd_count <= upd_count + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            inv_en  <= 1'b0;
            inv_idx <= '0;
            busy    <= 1'b0;
        end else if (inv_req) begin
            inv_en  <= 1'b1;
            inv_idx <= '0;
            busy    <= 1'b1;
        end else if (state == S_WALK) begin
            if (walk_last) begin
                inv_en  <= 1'b0;
                inv_idx <= '0;
                busy    <= 1'b0;
            end else begin
                inv_idx <= inv_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Randomized scoreboard bench for btb_update_scheduler: a queue model predicts accepts,
// issue order/timing and the invalidate walk; a negedge monitor checks DUT outputs.
module tb_btb_update_scheduler;

    localparam int DEPTH = 4;
    localparam int SETS  = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] bta;
        logic [1:0]  t;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] bta;
        logic [1:0]  t;
        int          due;
    } upd_t;

    logic        clk;
    logic        resetn;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_pc, req0_bta, req1_pc, req1_bta;
    logic [1:0]  req0_type, req1_type;
    logic        inv_req;
    logic        update_en;
    logic [31:0] update_pc, update_BTA;
    logic [1:0]  update_type;
    logic        inv_en;
    logic [4:0]  inv_idx;
    logic        busy;
    logic [15:0] upd_count;

    btb_update_scheduler #(.DEPTH(DEPTH), .SETS(SETS), .IDX_W(5)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_pc(req0_pc),
        .req0_bta(req0_bta), .req0_type(req0_type),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_pc(req1_pc),
        .req1_bta(req1_bta), .req1_type(req1_type),
        .inv_req(inv_req),
        .update_en(update_en), .update_pc(update_pc), .update_BTA(update_BTA),
        .update_type(update_type),
        .inv_en(inv_en), .inv_idx(inv_idx), .busy(busy), .upd_count(upd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   issued = 0;
    ent_t mq[$];
    upd_t exp_upd[$];
    bit   exp_walk = 0;
    int   exp_idx  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: consumes the scoreboard whenever the DUT strobes, and tracks the walk.
    initial begin
        upd_t e;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1) begin
                if (update_en === 1'b1) begin
                    if (exp_upd.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_update: got pc %0h want no strobe (cycle %0d)", update_pc, cyc);
                    end else begin
                        e = exp_upd.pop_front();
                        issued++;
                        chk("update_pc", update_pc, e.pc);
                        chk("update_bta", update_BTA, e.bta);
                        chk("update_type", update_type, e.t);
                        chk("update_cycle", cyc, e.due);
                        chk("upd_count", upd_count, (issued > 65535) ? 65535 : issued);
                    end
                end else if (exp_upd.size() > 0 && exp_upd[0].due <= cyc) begin
                    total++; bad++;
                    $display("FAIL missing_update: got no strobe want pc %0h (cycle %0d)", exp_upd[0].pc, cyc);
                    void'(exp_upd.pop_front());
                end
                chk("inv_en", inv_en, exp_walk);
                chk("busy", busy, exp_walk);
                if (exp_walk) chk("inv_idx", inv_idx, exp_idx);
            end
        end
    end

    // One cycle of stimulus; the model advances on the clock edge.
    task automatic step(input bit v0, input bit v1, input bit inv, input ent_t e0, input ent_t e1,
                        output bit a0, output bit a1);
        bit r0, r1;
        int pend;
        ent_t h;
        @(negedge clk); #1;
        req0_valid = v0; req0_pc = e0.pc; req0_bta = e0.bta; req0_type = e0.t;
        req1_valid = v1; req1_pc = e1.pc; req1_bta = e1.bta; req1_type = e1.t;
        inv_req = inv;
        pend = mq.size();
        r0 = !exp_walk && (pend <= DEPTH - 1);
        r1 = !exp_walk && ((pend + ((v0 && r0) ? 1 : 0)) <= DEPTH - 1);
        a0 = v0 && r0;
        a1 = v1 && r1;
        #1;
        chk("req0_ready", req0_ready, r0);
        chk("req1_ready", req1_ready, r1);
        @(posedge clk);
        cyc++;
        if (inv) begin
            mq.delete();
            exp_walk = 1;
            exp_idx  = 0;
        end else begin
            if (exp_walk) begin
                if (exp_idx == SETS - 1) begin
                    exp_walk = 0;
                    exp_idx  = 0;
                end else begin
                    exp_idx++;
                end
            end else if (pend > 0) begin
                h = mq.pop_front();
                exp_upd.push_back('{h.pc, h.bta, h.t, cyc});
            end
            if (a0) mq.push_back(e0);
            if (a1) mq.push_back(e1);
        end
    endtask

    task automatic idle(input int n);
        bit a0, a1;
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, a0, a1);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        resetn = 0;
        req0_valid = 0; req1_valid = 0; inv_req = 0;
        mq.delete(); exp_upd.delete();
        exp_walk = 0; exp_idx = 0; issued = 0;
        @(posedge clk);
        @(negedge clk); #1;
        chk("rst_update_en", update_en, 0);
        chk("rst_update_pc", update_pc, 0);
        chk("rst_update_bta", update_BTA, 0);
        chk("rst_update_type", update_type, 0);
        chk("rst_inv_en", inv_en, 0);
        chk("rst_inv_idx", inv_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_upd_count", upd_count, 0);
        resetn = 1;
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e.pc  = $urandom;
        e.bta = $urandom;
        e.t   = 2'($urandom_range(0, 3));
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test end");
        $fatal(1, "timeout");
    end

    initial begin
        bit   a0, a1;
        ent_t e0, e1;
        int   k, guard;
        resetn = 0; req0_valid = 0; req1_valid = 0; inv_req = 0;
        req0_pc = 0; req0_bta = 0; req0_type = 0;
        req1_pc = 0; req1_bta = 0; req1_type = 0;
        do_reset();

        // Single port-0 update.
        e0 = '{32'h0040_0010, 32'h0040_0100, 2'b00};
        step(1, 0, 0, e0, '0, a0, a1);
        idle(4);

        // Both ports, empty FIFO: A then B on consecutive cycles.
        e0 = '{32'h0000_0100, 32'h0000_1000, 2'b01};
        e1 = '{32'h0000_0204, 32'h0000_2000, 2'b10};
        step(1, 1, 0, e0, e1, a0, a1);
        idle(5);

        // Both ports held valid until 20 requests have been taken.
        k = 0; guard = 0;
        while (k < 20 && guard < 200) begin
            e0 = '{32'h1000 + 32'(k * 4), 32'h8000 + 32'(k), 2'(k)};
            e1 = '{32'h1000 + 32'((k + 1) * 4), 32'h8000 + 32'(k + 1), 2'(k + 1)};
            step(1, k < 19, 0, e0, e1, a0, a1);
            if (a0) begin
                k++;
                if (a1) k++;
            end
            guard++;
        end
        chk("hold_requests_taken", k, 20);
        idle(8);

        // Three queued entries then a flush: queued entries must never issue.
        e0 = '{32'hA000_0000, 32'h1, 2'b11};
        e1 = '{32'hA000_0004, 32'h2, 2'b11};
        step(1, 1, 0, e0, e1, a0, a1);
        e0 = '{32'hA000_0008, 32'h3, 2'b00};
        step(1, 0, 0, e0, '0, a0, a1);
        step(0, 0, 1, '0, '0, a0, a1);
        idle(SETS + 2);
        e0 = '{32'hB000_0000, 32'h4, 2'b01};
        step(1, 0, 0, e0, '0, a0, a1);
        chk("post_walk_accept", a0, 1);
        idle(4);

        // Restart the walk at index 10.
        step(0, 0, 1, '0, '0, a0, a1);
        guard = 0;
        while (!(exp_walk && exp_idx == 10) && guard < 64) begin
            idle(1);
            guard++;
        end
        step(0, 0, 1, '0, '0, a0, a1);
        idle(SETS + 2);

        // Reset in the middle of a walk with traffic queued.
        e0 = rnd_ent(); e1 = rnd_ent();
        step(1, 1, 0, e0, e1, a0, a1);
        step(0, 0, 1, '0, '0, a0, a1);
        guard = 0;
        while (!(exp_walk && exp_idx == 5) && guard < 64) begin
            idle(1);
            guard++;
        end
        do_reset();
        idle(3);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 700; i++) begin
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55,
                 $urandom_range(0, 149) == 0, rnd_ent(), rnd_ent(), a0, a1);
        end
        idle(SETS + 8);
        chk("drain_scoreboard", exp_upd.size(), 0);
        chk("drain_model", mq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
